// File: rtl/cpu_csr_rmw_pkg.sv
// Shared CSR types for the CSR read-modify-write unit: address/word types,
// funct3 operation encodings and the sequencer state encoding.
package common;

  typedef logic [11:0] csr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } rmw_state_t;

  // funct3 low bits of 00 (000 / 100) are not CSR instructions
  function automatic logic csr_op_legal(input logic [2:0] op);
    return op[1:0] != 2'b00;
  endfunction

  // RW and RWI both have low bits 01
  function automatic logic csr_op_is_write(input logic [2:0] op);
    return op[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/cpu_csr_rmw_if.sv
// Bus bundle for the CSR RMW unit: request from execute, CSR file read/write
// port and response back to the pipeline. slave = the unit, master = its environment.
interface cpu_csr_rmw_if;
  import common::*;

  logic       req_valid_i;
  logic       req_ready_o;
  logic [2:0] req_op_i;
  csr_t       req_addr_i;
  word_t      req_rs1_data_i;
  logic [4:0] req_rs1_idx_i;
  logic [4:0] req_rd_idx_i;

  csr_t       csr_read_addr_o;
  logic       csr_read_enable_o;
  word_t      csr_read_data_i;

  csr_t       csr_write_addr_o;
  word_t      csr_write_data_o;
  logic       csr_write_enable_o;

  logic       rsp_valid_o;
  logic       rsp_ready_i;
  word_t      rsp_data_o;
  logic       rsp_illegal_o;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_rs1_data_i, req_rs1_idx_i, req_rd_idx_i,
    input  csr_read_data_i, rsp_ready_i,
    output req_ready_o, csr_read_addr_o, csr_read_enable_o,
    output csr_write_addr_o, csr_write_data_o, csr_write_enable_o,
    output rsp_valid_o, rsp_data_o, rsp_illegal_o
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_rs1_data_i, req_rs1_idx_i, req_rd_idx_i,
    output csr_read_data_i, rsp_ready_i,
    input  req_ready_o, csr_read_addr_o, csr_read_enable_o,
    input  csr_write_addr_o, csr_write_data_o, csr_write_enable_o,
    input  rsp_valid_o, rsp_data_o, rsp_illegal_o
  );

endinterface

// File: rtl/cpu_csr_rmw.sv
// CSR read-modify-write sequencer: one CSR instruction per 4+ cycles.
// Optional macro CSR_RO_WRITE_TRAP_EN traps writes to read-only CSRs (addr[11:10]=11).
//
// state | meaning
// IDLE  | ready for a new CSR instruction
// READ  | CSR read strobe issued (unless suppressed for RW/RWI with rd=0)
// WRITE | read data captured, new value computed and written (unless suppressed)
// RESP  | old value / illegal flag held until the pipeline takes it
module cpu_csr_rmw
  import common::*;
(
  input logic          clk_i,
  input logic          reset_ni,
  cpu_csr_rmw_if.slave bus
);

  rmw_state_t state_q, state_d;

  logic [2:0] op_q;
  csr_t       addr_q;
  word_t      operand_q;
  logic [4:0] rs1_idx_q;
  logic [4:0] rd_idx_q;
  word_t      old_q;
  logic       illegal_q;

  logic  legal;
  logic  rd_en;
  logic  wr_intent;
  logic  trap;
  logic  wr_en;
  word_t old_d;
  word_t new_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.req_valid_i) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Decode from the registered instruction; stable from READ through RESP.
  always_comb begin
    legal     = csr_op_legal(op_q);
    rd_en     = legal && !(csr_op_is_write(op_q) && (rd_idx_q == 5'd0));
    wr_intent = legal && (csr_op_is_write(op_q) || (rs1_idx_q != 5'd0));
`ifdef CSR_RO_WRITE_TRAP_EN
    trap      = wr_intent && (addr_q[11:10] == 2'b11);
`else
    trap      = 1'b0;
`endif
    wr_en     = wr_intent && !trap;
    old_d     = rd_en ? bus.csr_read_data_i : '0;
  end

  always_comb begin
    new_d = old_d & ~operand_q;
    case (op_q)
      CSR_RW, CSR_RWI: new_d = operand_q;
      CSR_RS, CSR_RSI: new_d = old_d | operand_q;
      default:         new_d = old_d & ~operand_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      rs1_idx_q <= '0;
      rd_idx_q  <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.req_valid_i) begin
        op_q      <= bus.req_op_i;
        addr_q    <= bus.req_addr_i;
        operand_q <= bus.req_op_i[2] ? {27'd0, bus.req_rs1_idx_i} : bus.req_rs1_data_i;
        rs1_idx_q <= bus.req_rs1_idx_i;
        rd_idx_q  <= bus.req_rd_idx_i;
      end
      if (state_q == ST_WRITE) begin
        old_q     <= old_d;
        illegal_q <= !legal || trap;
      end
    end
  end

  always_comb begin
    bus.req_ready_o        = 1'b0;
    bus.csr_read_addr_o    = '0;
    bus.csr_read_enable_o  = 1'b0;
    bus.csr_write_addr_o   = '0;
    bus.csr_write_data_o   = '0;
    bus.csr_write_enable_o = 1'b0;
    bus.rsp_valid_o        = 1'b0;
    bus.rsp_data_o         = '0;
    bus.rsp_illegal_o      = 1'b0;
    unique case (state_q)
      ST_IDLE: bus.req_ready_o = 1'b1;
      ST_READ: begin
        bus.csr_read_addr_o   = addr_q;
        bus.csr_read_enable_o = rd_en;
      end
      ST_WRITE: begin
        bus.csr_write_addr_o   = addr_q;
        bus.csr_write_data_o   = new_d;
        bus.csr_write_enable_o = wr_en;
      end
      ST_RESP: begin
        bus.rsp_valid_o   = 1'b1;
        bus.rsp_data_o    = old_q;
        bus.rsp_illegal_o = illegal_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_csr_rmw.md
CPU_CSR_RMW -- requirements
Module: cpu_csr_rmw

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; reset_ni  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: req_valid_i  in  1  CSR instruction offered by execute stage; req_ready_o  out  1  block can accept.
REQ-003 SHALL have: req_op_i  in  3  funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI); req_addr_i  in  12 (csr_t)  CSR address.
REQ-004 SHALL have: req_rs1_data_i  in  32  rs1 value; req_rs1_idx_i  in  5  rs1 field / uimm; req_rd_idx_i  in  5  rd field.
REQ-005 SHALL have: csr_read_addr_o  out  12; csr_read_enable_o  out  1; csr_read_data_i  in  32, valid one cycle after enable.
REQ-006 SHALL have: csr_write_addr_o  out  12; csr_write_data_o  out  32; csr_write_enable_o  out  1.
REQ-007 SHALL have: rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_data_o  out  32  old CSR value for rd; rsp_illegal_o  out  1  illegal-instruction flag.

Function
REQ-008 SHALL implement FSM IDLE -> READ -> WRITE -> RESP -> IDLE; req_ready_o=1 only in IDLE.
REQ-009 SHALL, on req_valid_i&&req_ready_o in IDLE, register op, addr, operand, rs1_idx, rd_idx and enter READ.
REQ-010 SHALL use operand = req_rs1_data_i for op[2]=0, zero-extended req_rs1_idx_i for op[2]=1.
REQ-011 SHALL, in READ, drive csr_read_addr_o=addr and csr_read_enable_o=1, except RW/RWI with rd_idx=0 (enable=0).
REQ-012 SHALL, in WRITE, capture csr_read_data_i as old value (0 when read was suppressed).
REQ-013 SHALL, in WRITE, compute new = operand (RW/RWI), old|operand (RS/RSI), old&~operand (RC/RCI).
REQ-014 SHALL, in WRITE, assert csr_write_enable_o for exactly that cycle with csr_write_addr_o=addr, csr_write_data_o=new, except RS/RSI/RC/RCI with rs1_idx=0 (no write).
REQ-015 SHALL treat op 000 and 100 as illegal: no read, no write, rsp_illegal_o=1, rsp_data_o=0.
REQ-016 SHALL, in RESP, hold rsp_valid_o=1 with stable rsp_data_o/rsp_illegal_o until rsp_ready_i=1, then go IDLE.
REQ-017 SHALL give latency: accept at cycle N -> read cycle N+1 -> write cycle N+2 -> rsp_valid_o from N+3; throughput max one op per 4 cycles.
REQ-018 SHALL ignore req_valid_i outside IDLE; no new request is accepted in the cycle RESP completes.
REQ-019 SHALL keep csr_read_enable_o and csr_write_enable_o at 0 in every state other than READ and WRITE respectively.

Reset
REQ-020 SHALL, on reset_ni=0 at any time (including mid-operation), enter IDLE asynchronously, drive all outputs 0 except req_ready_o=1, and discard the in-flight operation without a write.

Configuration
REQ-021 SHALL, with CSR_RO_WRITE_TRAP_EN defined, flag any write-intent operation (REQ-014 write condition true) to addr[11:10]=2'b11 as illegal: write suppressed, read still performed, rsp_illegal_o=1.
REQ-022 SHALL, without CSR_RO_WRITE_TRAP_EN, issue such writes normally and tie rsp_illegal_o to the REQ-015 condition only.

Structure
REQ-023 SHALL place csr_op_t enum (six funct3 encodings) in package common alongside csr_t and word_t.
REQ-024 SHALL be a single module with no sub-module; the RMW ALU is inline combinational logic.

Verification
REQ-025 SHALL cover: CSRRW mscratch(0x340) rs1=0xDEADBEEF, rd=5, prior value 0x12345678 -> write 0xDEADBEEF at cycle N+2, rsp_data_o=0x12345678 at N+3.
REQ-026 SHALL cover: CSRRS 0x340 rs1_idx=0, prior value 0x000000FF -> no write_enable, rsp_data_o=0x000000FF.
REQ-027 SHALL cover: CSRRCI 0x340 uimm=0x0F, prior value 0xFFFFFFFF -> write 0xFFFFFFF0, rsp_data_o=0xFFFFFFFF.
REQ-028 SHALL cover: CSRRW 0xF11 rs1_idx=1 with macro -> no write, rsp_illegal_o=1; without macro -> write issued, rsp_illegal_o=0.
REQ-029 SHALL cover: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o/rsp_data_o stable, req_ready_o=0 throughout; release -> IDLE next cycle.
REQ-030 SHALL cover: reset_ni pulsed low during READ -> immediate IDLE, no write_enable, req_ready_o=1 after release.
